// File: rtl/memsys_prims_pkg.sv
// Shared constants and helpers for the memory-subsystem primitive cells:
// crossbar control encodings, decoder widths and the one-hot decode function.
package memsys_prims_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic SWAP_STRAIGHT = 1'b0;
    localparam logic SWAP_CROSSED  = 1'b1;

    localparam int DEC_IN  = 2;
    localparam int DEC_OUT = 4;

    function automatic logic [DEC_OUT-1:0] dec_onehot(input logic [DEC_IN-1:0] s);
        logic [DEC_OUT-1:0] r;
        case (s)
            2'd0:    r = 4'b0001;
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            2'd3:    r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/memsys_enreg.sv
// Enabled register with synchronous active-high reset; reset beats enable.
// Reused standalone for pointers and per-entry valid flags.
module memsys_enreg
    import memsys_prims_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // next-state: load when enabled, otherwise hold
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // state register, reset sampled on the clock edge only
    always_ff @(posedge ph1) begin
        if (reset) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/memsys_prims.sv
// Primitive cell bundle: two-way swap crossbar, 2-to-4 one-hot decoder and an
// enabled register. The three functions share no state.
module memsys_prims
    import memsys_prims_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic                ph1,
    input  logic                reset,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                swap,
    output logic [WIDTH-1:0]    y0,
    output logic [WIDTH-1:0]    y1,
    input  logic [DEC_IN-1:0]   sel,
    output logic [DEC_OUT-1:0]  onehot,
    input  logic                en,
    input  logic [WIDTH-1:0]    d,
    output logic [WIDTH-1:0]    q
);

    // crossbar routing; outputs always driven, independent of clock and reset
    always_comb begin
        y0 = a;
        y1 = b;
        case (swap)
            SWAP_STRAIGHT: begin
                y0 = a;
                y1 = b;
            end
            SWAP_CROSSED: begin
                y0 = b;
                y1 = a;
            end
            default: begin
                y0 = a;
                y1 = b;
            end
        endcase
    end

    // pointer decode, deliberately untouched by reset
    always_comb begin
        onehot = dec_onehot(sel);
    end

    memsys_enreg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_enreg (
        .ph1   (ph1),
        .reset (reset),
        .en    (en),
        .d     (d),
        .q     (q)
    );

endmodule

// File: tb/tb_memsys_prims.sv
// Self-checking bench for memsys_prims: table-driven crossbar/decoder vectors,
// scoreboard-checked register, and a 2-bit pointer instance driving its decoder.
module tb_memsys_prims;

    logic        ph1;
    logic        reset;
    logic [31:0] a, b;
    logic        swap;
    logic [31:0] y0, y1;
    logic [1:0]  sel;
    logic [3:0]  onehot;
    logic        en;
    logic [31:0] d;
    logic [31:0] q;

    logic        p_reset;
    logic [1:0]  p_a, p_b, p_y0, p_y1, p_d, p_q;
    logic [3:0]  p_onehot;

    int tests  = 0;
    int failed = 0;

    logic [31:0] sb_q[$];
    logic [31:0] model_q;

    memsys_prims #(.WIDTH(32), .RST_VAL(32'h0000_0000)) dut (
        .ph1(ph1), .reset(reset), .a(a), .b(b), .swap(swap), .y0(y0), .y1(y1),
        .sel(sel), .onehot(onehot), .en(en), .d(d), .q(q)
    );

    memsys_prims #(.WIDTH(2), .RST_VAL(2'b00)) ptr (
        .ph1(ph1), .reset(p_reset), .a(p_a), .b(p_b), .swap(1'b1), .y0(p_y0), .y1(p_y1),
        .sel(p_q), .onehot(p_onehot), .en(1'b1), .d(p_d), .q(p_q)
    );

    assign p_d = p_q + 2'd1;

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clock edge: predict q, push it, then pop and compare after the edge
    task automatic step(input string name);
        logic [31:0] e;
        if (reset) model_q = 32'h0000_0000;
        else if (en) model_q = d;
        sb_q.push_back(model_q);
        @(posedge ph1);
        #1;
        e = sb_q.pop_front();
        chk(name, q, e);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        swap;
        logic [1:0]  sel;
        logic        rst;
        logic [31:0] y0;
        logic [31:0] y1;
        logic [3:0]  oh;
    } vec_t;

    vec_t vecs[8];
    logic [1:0] ptr_exp_q[5];
    logic [3:0] ptr_exp_oh[5];

    initial begin
        vecs[0] = '{32'h12345678, 32'hCAFEBABE, 1'b0, 2'd0, 1'b0, 32'h12345678, 32'hCAFEBABE, 4'b0001};
        vecs[1] = '{32'h12345678, 32'hCAFEBABE, 1'b1, 2'd1, 1'b0, 32'hCAFEBABE, 32'h12345678, 4'b0010};
        vecs[2] = '{32'h12345678, 32'hCAFEBABE, 1'b0, 2'd2, 1'b1, 32'h12345678, 32'hCAFEBABE, 4'b0100};
        vecs[3] = '{32'h12345678, 32'hCAFEBABE, 1'b1, 2'd3, 1'b1, 32'hCAFEBABE, 32'h12345678, 4'b1000};
        vecs[4] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0001};
        vecs[5] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 2'd1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0010};
        vecs[6] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h00000000, 4'b0100};
        vecs[7] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 2'd3, 1'b1, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
        ptr_exp_q  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        ptr_exp_oh = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

        a = 32'h0; b = 32'h0; swap = 1'b0; sel = 2'd0;
        p_a = 2'b01; p_b = 2'b10; p_reset = 1'b1;
        model_q = 32'h0;

        // register reset with en=1, d all ones, for two edges
        reset = 1'b1; en = 1'b1; d = 32'hFFFF_FFFF;
        @(negedge ph1);
        step("reset_q_edge1");
        step("reset_q_edge2");
        chk("reset_q_zero", q, 32'h0000_0000);
        // release with en=1: reset still owns the release edge, d loads next
        reset = 1'b0;
        step("release_load");
        chk("release_q_ones", q, 32'hFFFF_FFFF);

        // combinational table; register held (en=0) except where reset is set
        en = 1'b0; d = 32'h1357_9BDF;
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; swap = vecs[i].swap;
            sel = vecs[i].sel; reset = vecs[i].rst;
            #1;
            chk($sformatf("xbar_y0_%0d", i), y0, vecs[i].y0);
            chk($sformatf("xbar_y1_%0d", i), y1, vecs[i].y1);
            chk($sformatf("dec_oh_%0d", i), {28'h0, onehot}, {28'h0, vecs[i].oh});
            step($sformatf("vec_q_%0d", i));
        end
        reset = 1'b0;

        // enable then hold
        en = 1'b1; d = 32'hA5A5_A5A5;
        step("load_a5");
        chk("load_a5_abs", q, 32'hA5A5_A5A5);
        en = 1'b0; d = 32'h5A5A_5A5A;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("hold_%0d", i));
            chk($sformatf("hold_abs_%0d", i), q, 32'hA5A5_A5A5);
        end
        en = 1'b1;
        step("load_5a");
        chk("load_5a_abs", q, 32'h5A5A_5A5A);

        // reset priority over enable; no effect between edges
        d = 32'h0000_BEEF;
        step("load_beef");
        reset = 1'b1; d = 32'h1111_1111;
        #2;
        chk("no_async_reset", q, 32'h0000_BEEF);
        step("reset_priority");
        chk("reset_priority_abs", q, 32'h0000_0000);
        reset = 1'b0;
        step("post_reset_load");
        chk("post_reset_abs", q, 32'h1111_1111);

        // 2-bit pointer counting through its own decoder
        en = 1'b0;
        step("ptr_reset_edge");
        chk("ptr_reset_q", {30'h0, p_q}, 32'h0);
        chk("ptr_reset_oh", {28'h0, p_onehot}, 32'h1);
        p_reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step($sformatf("ptr_main_hold_%0d", i));
            chk($sformatf("ptr_q_%0d", i), {30'h0, p_q}, {30'h0, ptr_exp_q[i]});
            chk($sformatf("ptr_oh_%0d", i), {28'h0, p_onehot}, {28'h0, ptr_exp_oh[i]});
        end
        chk("ptr_xbar_y0", {30'h0, p_y0}, 32'h2);
        chk("ptr_xbar_y1", {30'h0, p_y1}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/memsys_prims.md
Name: memsys_prims

Overview:
- Primitive cell bundle used throughout the memory subsystem: I/D cache port routing, pointer decoding and enabled state registers.
- Three independent functions in one block:
  - two-way swap crossbar (cmux2 function);
  - 2-to-4 one-hot decoder (dec2 function);
  - enabled, synchronously reset register (flopenr function).
- Only the register is sequential. Crossbar and decoder are purely combinational.

Parameters:
- WIDTH, 32, data width of crossbar channels and of the register.
- RST_VAL, 0, value loaded into q on reset (WIDTH bits).

Ports:
- ph1  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- a  in  WIDTH  crossbar channel A
- b  in  WIDTH  crossbar channel B
- swap  in  1  crossbar control: 0 = straight, 1 = swapped
- y0  out  WIDTH  crossbar output 0
- y1  out  WIDTH  crossbar output 1
- sel  in  2  decoder input
- onehot  out  4  decoder output
- en  in  1  register load enable
- d  in  WIDTH  register data in
- q  out  WIDTH  register data out

Behaviour:
- Interface: one clock (ph1); reset is synchronous and active-high.
- Crossbar (combinational, zero latency):
  - swap=0: y0=a, y1=b.
  - swap=1: y0=b, y1=a.
  - Both outputs are always driven; no tristate.
  - a==b gives y0==y1 regardless of swap.
  - No dependence on clock or reset.
- Decoder (combinational):
  - onehot[i]=1 exactly when sel==i, i in 0..3; all other bits 0.
  - The output always has exactly one bit set for known sel.
  - Not affected by reset.
- Register (clocked on rising ph1):
  - reset=1: q <= RST_VAL on the next edge, regardless of en or d. Reset has priority over en.
  - reset=0, en=1: q <= d. One-cycle latency: d sampled at edge k appears on q after edge k.
  - reset=0, en=0: q holds its value.
  - Reset asserted mid-operation clears q at the next edge; no asynchronous effect between edges.
  - Reset deasserted with en=1 on the same edge: the reset value still wins that edge; d loads on the following edge.
  - q before the first reset edge is undefined. The bench must apply reset for at least 1 cycle before checking.
- Reset values of outputs:
  - q = RST_VAL.
  - y0, y1 and onehot follow their inputs; they have no reset state.
- The three functions share no state. Activity on one must not disturb the others.

Decomposition:
- Shared package holds:
  - WIDTH default (32);
  - SWAP_STRAIGHT=1'b0 and SWAP_CROSSED=1'b1 constants;
  - decoder width constants (IN=2, OUT=4).
- Sub-modules:
  - The register is the natural sub-module (memsys_enreg). It is instantiated per width by callers, such as write-buffer pointers and per-entry valid flags.
  - Crossbar and decoder are small enough to stay inline.

Test Plan:
- Crossbar, a=0x12345678, b=0xCAFEBABE:
  - swap=0 -> y0=0x12345678, y1=0xCAFEBABE;
  - swap=1 -> y0=0xCAFEBABE, y1=0x12345678;
  - toggle swap each cycle and check with zero delay.
- Decoder, sweep sel=0,1,2,3 -> onehot=0001,0010,0100,1000. Assert reset during the sweep -> outputs unchanged.
- Register reset, d=0xFFFFFFFF, en=1, reset=1 for 2 edges -> q=0x00000000. Release reset with en=1 -> q=0xFFFFFFFF one edge later.
- Register enable/hold:
  - en=1, d=0xA5A5A5A5 -> q=0xA5A5A5A5 after 1 edge;
  - en=0, d=0x5A5A5A5A for 3 edges -> q stays 0xA5A5A5A5;
  - en=1 -> q=0x5A5A5A5A.
- Reset priority: q=0x0000BEEF, assert reset with en=1, d=0x11111111 -> q=0x00000000 at the next edge, not 0x11111111.
- Pointer use case: 2-bit register (WIDTH=2) with d=q+1 and en=1 for 5 edges after reset -> q sequence 1,2,3,0,1 (wraps 3->0). onehot fed from q follows 0010,0100,1000,0001,0010.
